// File: rtl/labfinal_soc_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : labfinal_soc_spi_slave
// Brief    : Mode-0, 8-bit MSB-first SPI slave with a two-cycle CPU register
//            port. Optional EOP detection enabled by `define SPI_SLAVE_EOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module labfinal_soc_spi_slave #(
    parameter int DATABITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam int                BW     = $clog2(DATABITS);
    localparam logic [BW-1:0]     c_last = BW'(DATABITS - 1);
    localparam logic [15-DATABITS:0] c_pad = '0;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sclk_d, r_ss_d;
    logic [BW-1:0]          r_bitcnt;
    logic [DATABITS-2:0]    r_rx_shift;
    logic [DATABITS-1:0]    r_rx_holding, r_tx_shift, r_tx_holding;
    logic                   r_tx_primed, r_rrdy, r_roe, r_toe;
    logic                   r_iroe, r_itoe, r_itrdy, r_irrdy, r_ie;
    logic                   r_rd_seen, r_wr_seen, r_rd_stb, r_wr_stb;
    logic [2:0]             r_addr;
    logic [9:0]             r_wdata;
    logic                   r_irq;
    logic [15:0]            r_rdata;

    logic w_sclk_s, w_ss_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic w_active, w_last_bit, w_byte_done, w_load;
    logic [DATABITS-1:0] w_rx_byte;
    logic w_rd_req, w_wr_req, w_rd_rx, w_wr_tx, w_wr_status, w_wr_ctrl, w_wr_eop;
    logic w_tx_accept, w_trdy, w_tmt, w_e, w_eop, w_ieop;
    logic [15:0] w_status, w_ctrl, w_eop_word, w_rd_word;
    logic w_unused;

    // Pad synchronizers; SS_n idles high so its chain resets to 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall   = ~w_ss_s & r_ss_d;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_ss_fall) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_ss_rise) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_active    = (r_state == S_ACTIVE);
    assign w_last_bit  = (r_bitcnt == c_last);
    assign w_rx_byte   = {r_rx_shift, w_mosi_s};
    assign w_byte_done = w_active & ~w_ss_rise & w_sclk_rise & w_last_bit;
    assign w_load      = (~w_active & w_ss_fall) | w_byte_done;

    // Bus strobes fire once per assertion and re-arm after an idle cycle.
    assign w_rd_req    = spi_select & ~read_n;
    assign w_wr_req    = spi_select & ~write_n;
    assign w_rd_rx     = r_rd_stb & (r_addr == 3'd0);
    assign w_wr_tx     = r_wr_stb & (r_addr == 3'd1);
    assign w_wr_status = r_wr_stb & (r_addr == 3'd2);
    assign w_wr_ctrl   = r_wr_stb & (r_addr == 3'd3);
    assign w_wr_eop    = r_wr_stb & (r_addr == 3'd6);

    // A write coinciding with a reload is accepted: the reload empties the holding slot.
    assign w_tx_accept = w_wr_tx & (~r_tx_primed | w_load);
    assign w_trdy      = ~r_tx_primed;
    assign w_tmt       = ~r_tx_primed & ~w_active;
    assign w_e         = r_toe | r_roe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt     <= '0;
            r_rx_shift   <= '0;
            r_rx_holding <= '0;
            r_tx_shift   <= '0;
            r_tx_holding <= '0;
            r_tx_primed  <= 1'b0;
            r_rrdy       <= 1'b0;
            r_roe        <= 1'b0;
            r_toe        <= 1'b0;
        end else begin
            if (!w_active || w_ss_rise) begin
                r_bitcnt <= '0;
            end else if (w_sclk_rise) begin
                r_rx_shift <= w_rx_byte[DATABITS-2:0];
                r_bitcnt   <= w_last_bit ? '0 : r_bitcnt + BW'(1);
            end
            if (w_byte_done) r_rx_holding <= w_rx_byte;

            // The fall right after a byte boundary must not shift the freshly loaded byte.
            if (w_load)
                r_tx_shift <= r_tx_primed ? r_tx_holding : '0;
            else if (w_active && w_sclk_fall && (r_bitcnt != '0))
                r_tx_shift <= {r_tx_shift[DATABITS-2:0], 1'b0};

            if (w_tx_accept) begin
                r_tx_holding <= r_wdata[DATABITS-1:0];
                r_tx_primed  <= 1'b1;
            end else if (w_load) begin
                r_tx_primed  <= 1'b0;
            end

            if (w_byte_done)                    r_rrdy <= 1'b1;
            else if (w_rd_rx || w_wr_status)    r_rrdy <= 1'b0;

            if (w_wr_status)                         r_roe <= 1'b0;
            else if (w_byte_done && r_rrdy && !w_rd_rx) r_roe <= 1'b1;

            if (w_wr_status)                    r_toe <= 1'b0;
            else if (w_wr_tx && !w_tx_accept)   r_toe <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_EOP_EN
    logic [DATABITS-1:0] r_eop_val;
    logic                r_eop, r_ieop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eop_val <= '0;
            r_eop     <= 1'b0;
            r_ieop    <= 1'b0;
        end else begin
            if (w_wr_eop)  r_eop_val <= r_wdata[DATABITS-1:0];
            if (w_wr_ctrl) r_ieop    <= r_wdata[9];
            if (w_byte_done && (w_rx_byte == r_eop_val)) r_eop <= 1'b1;
            else if (w_wr_status)                         r_eop <= 1'b0;
        end
    end

    assign w_eop      = r_eop;
    assign w_ieop     = r_ieop;
    assign w_eop_word = {c_pad, r_eop_val};
`else
    assign w_eop      = 1'b0;
    assign w_ieop     = 1'b0;
    assign w_eop_word = 16'h0000;
`endif

    assign w_status = {6'b0, w_eop, w_e, r_rrdy, w_trdy, w_tmt, r_toe, r_roe, 3'b0};
    assign w_ctrl   = {6'b0, w_ieop, r_ie, r_irrdy, r_itrdy, 1'b0, r_itoe, r_iroe, 3'b0};

    always_comb begin
        w_rd_word = 16'h0000;
        case (r_addr)
            3'd0:    w_rd_word = {c_pad, r_rx_holding};
            3'd2:    w_rd_word = w_status;
            3'd3:    w_rd_word = w_ctrl;
            3'd6:    w_rd_word = w_eop_word;
            default: w_rd_word = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_seen <= 1'b0;
            r_wr_seen <= 1'b0;
            r_rd_stb  <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_iroe    <= 1'b0;
            r_itoe    <= 1'b0;
            r_itrdy   <= 1'b0;
            r_irrdy   <= 1'b0;
            r_ie      <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_rd_seen <= w_rd_req;
            r_wr_seen <= w_wr_req;
            r_rd_stb  <= w_rd_req & ~r_rd_seen;
            r_wr_stb  <= w_wr_req & ~r_wr_seen;
            if ((w_rd_req && !r_rd_seen) || (w_wr_req && !r_wr_seen))
                r_addr <= mem_addr;
            if (w_wr_req && !r_wr_seen)
                r_wdata <= data_from_cpu[9:0];
            if (r_rd_stb)
                r_rdata <= w_rd_word;
            if (w_wr_ctrl) begin
                r_iroe  <= r_wdata[3];
                r_itoe  <= r_wdata[4];
                r_itrdy <= r_wdata[6];
                r_irrdy <= r_wdata[7];
                r_ie    <= r_wdata[8];
            end
            r_irq <= (w_eop & w_ieop) | (w_e & r_ie) | (r_rrdy & r_irrdy) |
                     (w_trdy & r_itrdy) | (r_toe & r_itoe) | (r_roe & r_iroe);
        end
    end

    assign MISO          = r_tx_shift[DATABITS-1];
    assign MISO_oe       = ~w_ss_s;
    assign data_to_cpu   = r_rdata;
    assign irq           = r_irq;
    assign dataavailable = r_rrdy;
    assign readyfordata  = w_trdy;
    assign w_unused      = &{1'b0, data_from_cpu[15:10], r_wdata[9]};

endmodule
`default_nettype wire
